arbitro_mux1bit: RTL

Round-robin arbiter that shares the 1-bit mux datapath (`mux1bit_tarea34`) between two requesters, A and B. It owns the mux `selector`, grants one requester at a time with a bounded burst length, and registers the selected bit with a `valid` strobe. It sits between the requesters and the downstream consumer of `salida`, and it is driven by the same `clk` as the probador.

---
 rtl/arbitro_mux1bit_pkg.sv | 15 +
 rtl/arbitro_mux1bit_contador.sv | 28 ++
 rtl/mux1bit_tarea34.sv | 11 +
 rtl/arbitro_mux1bit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/arbitro_mux1bit_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arbitro_mux1bit_pkg;

  // Arbiter FSM encoding; the unused 2'b11 code falls back to idle.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StServA = 2'b01,
    StServB = 2'b10
  } arb_state_e;

  // Mux selector values.
  localparam logic SelA = 1'b0;
  localparam logic SelB = 1'b1;

endpackage

// File: rtl/arbitro_mux1bit_contador.sv
// Burst-length counter: counts transfers of the current grant and flags the last one.
module arbitro_mux1bit_contador #(
  parameter int unsigned MAX_RAFAGA = 4,
  parameter int unsigned CONT_W     = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic en,
  input  logic clr,
  output logic fin
);

  logic [CONT_W-1:0] cont_q;

  // Counter register; clear wins over enable so a terminal transfer starts a new burst.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cont_q <= '0;
    end else if (clr) begin
      cont_q <= '0;
    end else if (en) begin
      cont_q <= cont_q + 1'b1;
    end
  end

  assign fin = (cont_q == CONT_W'(MAX_RAFAGA - 1));

endmodule

// File: rtl/mux1bit_tarea34.sv
// 1-bit 2:1 mux shared by requesters A and B.
module mux1bit_tarea34 (
  input  logic a,
  input  logic b,
  input  logic selector,
  output logic salida
);

  assign salida = selector ? b : a;

endmodule

// File: rtl/arbitro_mux1bit.sv
// Round-robin arbiter sharing a 1-bit mux between requesters A and B with bounded bursts.
module arbitro_mux1bit
  import arbitro_mux1bit_pkg::*;
#(
  parameter int unsigned MAX_RAFAGA = 4,
  parameter int unsigned CONT_W     = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic req_A,
  input  logic req_B,
  input  logic A,
  input  logic B,
  output logic gnt_A,
  output logic gnt_B,
  output logic selector,
  output logic salida,
  output logic valid
);

  arb_state_e state_q, state_d;
  logic       ultimo_q, ultimo_d;
  logic       gnt_a_q, gnt_b_q;
  logic       sel_q, sel_d;
  logic       salida_q, valid_q;
  logic       transfer, cont_clr, cont_fin;
  logic       mux_out;

  arbitro_mux1bit_contador #(
    .MAX_RAFAGA (MAX_RAFAGA),
    .CONT_W     (CONT_W)
  ) u_contador (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (transfer),
    .clr     (cont_clr),
    .fin     (cont_fin)
  );

  mux1bit_tarea34 u_mux (
    .a        (A),
    .b        (B),
    .selector (sel_q),
    .salida   (mux_out)
  );

  // Next-state logic: detect transfers, burst end and handoffs.
  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    cont_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        cont_clr = 1'b1;
        if (req_A && req_B) begin
          // Tie goes to the side not served last.
          state_d = ultimo_q ? StServA : StServB;
        end else if (req_A) begin
          state_d = StServA;
        end else if (req_B) begin
          state_d = StServB;
        end
      end
      StServA: begin
        if (!req_A) begin
          cont_clr = 1'b1;
          state_d  = req_B ? StServB : StIdle;
        end else begin
          transfer = 1'b1;
          if (cont_fin) begin
            cont_clr = 1'b1;
            if (req_B) state_d = StServB;
          end
        end
      end
      StServB: begin
        if (!req_B) begin
          cont_clr = 1'b1;
          state_d  = req_A ? StServA : StIdle;
        end else begin
          transfer = 1'b1;
          if (cont_fin) begin
            cont_clr = 1'b1;
            if (req_A) state_d = StServA;
          end
        end
      end
      default: begin
        cont_clr = 1'b1;
        state_d  = StIdle;
      end
    endcase
  end

  // Selector and last-served flag follow the state being entered; both hold in idle.
  always_comb begin
    sel_d    = sel_q;
    ultimo_d = ultimo_q;
    if (state_d == StServA) begin
      sel_d    = SelA;
      ultimo_d = 1'b0;
    end else if (state_d == StServB) begin
      sel_d    = SelB;
      ultimo_d = 1'b1;
    end
  end

  // State, registered Moore outputs and the data output register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= StIdle;
      ultimo_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sel_q    <= SelA;
      salida_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ultimo_q <= ultimo_d;
      gnt_a_q  <= (state_d == StServA);
      gnt_b_q  <= (state_d == StServB);
      sel_q    <= sel_d;
      valid_q  <= transfer;
      if (transfer) salida_q <= mux_out;
    end
  end

  assign gnt_A    = gnt_a_q;
  assign gnt_B    = gnt_b_q;
  assign selector = sel_q;
  assign salida   = salida_q;
  assign valid    = valid_q;

endmodule
